// File: rtl/knn_scheduler.sv
// rtl/knn_scheduler.sv - k-NN inference scheduler
// Purpose: sequences one query: fetch each training sample, start the distance
//   calculation, write distances (then max-distance pads) into a 2^L slot array,
//   start the sort, wait for the k-type vote and hand the class to the host.
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_query_*/o_query_ready        host query handshake, count and base address
//   o_mem_req/o_mem_addr/i_mem_ack training-memory fetch
//   o_calc_start/i_calc_done       distance calculator
//   o_slot_write/pad/index         distance-array write port
//   o_sort_start/i_sort_valid      sorter
//   i_infer_done/i_infer_type      k-type vote result
//   o_result_*/i_result_ready      result handshake to host
//   o_busy, o_err, o_err_code      status (1 bad count, 2 timeout, 3 abort)
module knn_scheduler #(
    parameter int L       = 3,
    parameter int TYPE_W  = 4,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 1023
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_query_valid,
    output logic              o_query_ready,
    input  logic [L:0]        i_query_count,
    input  logic [ADDR_W-1:0] i_query_base,
    input  logic              i_query_abort,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_ack,
    output logic              o_calc_start,
    input  logic              i_calc_done,
    output logic              o_slot_write,
    output logic              o_slot_pad,
    output logic [L-1:0]      o_slot_index,
    output logic              o_sort_start,
    input  logic              i_sort_valid,
    input  logic              i_infer_done,
    input  logic [TYPE_W-1:0] i_infer_type,
    output logic              o_result_valid,
    output logic [TYPE_W-1:0] o_result_type,
    input  logic              i_result_ready,
    output logic              o_busy,
    output logic              o_err,
    output logic [1:0]        o_err_code
);
    localparam int         N_SLOTS   = 1 << L;
    localparam logic [L:0] SLOTS     = (L+1)'(N_SLOTS);
    localparam logic [L:0] LAST_SLOT = (L+1)'(N_SLOTS - 1);
    localparam int         WD_W      = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, FETCH, CALC, WAIT_CALC, WRITE, PAD, SORT, WAIT_SORT, WAIT_INFER, RESULT
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [L:0]          r_count, w_count_nxt;
    logic [ADDR_W-1:0]   r_base, w_base_nxt;
    logic [L:0]          r_slot, w_slot_nxt, w_slot_inc;
    logic [WD_W-1:0]     r_wdog;
    logic [TYPE_W-1:0]   r_result_type, w_type_nxt;
    logic                w_watched, w_timeout, w_err;
    logic [1:0]          w_err_code;

    logic                r_mem_req, r_calc_start, r_slot_write, r_slot_pad, r_sort_start;
    logic                r_result_valid, r_busy, r_err;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [L-1:0]        r_slot_index;
    logic [1:0]          r_err_code;

    assign w_slot_inc = r_slot + (L+1)'(1);
    assign w_watched  = (r_state == FETCH) || (r_state == WAIT_CALC) ||
                        (r_state == WAIT_SORT) || (r_state == WAIT_INFER);
    assign w_timeout  = w_watched && (r_wdog == WD_LIM);

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_base_nxt  = r_base;
        w_slot_nxt  = r_slot;
        w_type_nxt  = r_result_type;
        w_err       = 1'b0;
        w_err_code  = 2'd0;
        case (r_state)
            IDLE: if (i_query_valid) begin
                if (i_query_count == '0 || i_query_count > SLOTS) begin
                    w_err      = 1'b1;
                    w_err_code = 2'd1;
                end else begin
                    w_count_nxt = i_query_count;
                    w_base_nxt  = i_query_base;
                    w_slot_nxt  = '0;
                    w_state_nxt = FETCH;
                end
            end
            FETCH:     if (i_mem_ack)   w_state_nxt = CALC;
            CALC:      w_state_nxt = WAIT_CALC;
            WAIT_CALC: if (i_calc_done) w_state_nxt = WRITE;
            WRITE: begin
                if (w_slot_inc < r_count) begin
                    w_slot_nxt  = w_slot_inc;
                    w_state_nxt = FETCH;
                end else if (r_count < SLOTS) begin
                    w_slot_nxt  = w_slot_inc;
                    w_state_nxt = PAD;
                end else begin
                    w_state_nxt = SORT;
                end
            end
            PAD: begin
                if (r_slot == LAST_SLOT) w_state_nxt = SORT;
                else                     w_slot_nxt  = w_slot_inc;
            end
            SORT:      w_state_nxt = WAIT_SORT;
            WAIT_SORT: if (i_sort_valid) w_state_nxt = WAIT_INFER;
            WAIT_INFER: if (i_infer_done) begin
                w_type_nxt  = i_infer_type;
                w_state_nxt = RESULT;
            end
            RESULT:    if (i_result_ready) w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
        // A responder that finally answers on the limit cycle still wins;
        // the watchdog only fires when the state would otherwise stall.
        if (w_timeout && w_state_nxt == r_state) begin
            w_state_nxt = IDLE;
            w_err       = 1'b1;
            w_err_code  = 2'd2;
        end
        if (i_query_abort && r_state != IDLE) begin
            w_state_nxt = IDLE;
            w_err       = 1'b1;
            w_err_code  = 2'd3;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= IDLE;
            r_count        <= '0;
            r_base         <= '0;
            r_slot         <= '0;
            r_wdog         <= '0;
            r_result_type  <= '0;
            r_mem_req      <= 1'b0;
            r_mem_addr     <= '0;
            r_calc_start   <= 1'b0;
            r_slot_write   <= 1'b0;
            r_slot_pad     <= 1'b0;
            r_slot_index   <= '0;
            r_sort_start   <= 1'b0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_err          <= 1'b0;
            r_err_code     <= 2'd0;
        end else begin
            r_state        <= w_state_nxt;
            r_count        <= w_count_nxt;
            r_base         <= w_base_nxt;
            r_slot         <= w_slot_nxt;
            r_wdog         <= (w_watched && w_state_nxt == r_state) ? r_wdog + WD_W'(1) : '0;
            r_result_type  <= w_type_nxt;
            // Outputs are registered from the next state so they line up with it.
            r_mem_req      <= (w_state_nxt == FETCH);
            r_mem_addr     <= w_base_nxt + ADDR_W'(w_slot_nxt);
            r_calc_start   <= (w_state_nxt == CALC);
            r_slot_write   <= (w_state_nxt == WRITE) || (w_state_nxt == PAD);
            r_slot_pad     <= (w_state_nxt == PAD);
            r_slot_index   <= w_slot_nxt[L-1:0];
            r_sort_start   <= (w_state_nxt == SORT);
            r_result_valid <= (w_state_nxt == RESULT);
            r_busy         <= (w_state_nxt != IDLE);
            r_err          <= w_err;
            r_err_code     <= w_err_code;
        end
    end

    assign o_query_ready  = (r_state == IDLE);
    assign o_mem_req      = r_mem_req;
    assign o_mem_addr     = r_mem_addr;
    assign o_calc_start   = r_calc_start;
    assign o_slot_write   = r_slot_write;
    assign o_slot_pad     = r_slot_pad;
    assign o_slot_index   = r_slot_index;
    assign o_sort_start   = r_sort_start;
    assign o_result_valid = r_result_valid;
    assign o_result_type  = r_result_type;
    assign o_busy         = r_busy;
    assign o_err          = r_err;
    assign o_err_code     = r_err_code;
endmodule

// File: tb/tb_knn_scheduler.sv
// tb/tb_knn_scheduler.sv - self-checking bench for knn_scheduler
module tb_knn_scheduler;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       query_valid, query_abort, mem_ack, calc_done, sort_valid, infer_done, result_ready;
    logic [3:0] query_count, infer_type;
    logic [9:0] query_base;
    logic       query_ready, mem_req, calc_start, slot_write, slot_pad, sort_start;
    logic       result_valid, busy, err;
    logic [9:0] mem_addr;
    logic [2:0] slot_index;
    logic [3:0] result_type;
    logic [1:0] err_code;

    int checks = 0;
    int failures = 0;

    // responder mode: 0 silent, 1 zero-wait, 2 random (75% ready per cycle)
    int rmode = 0;
    bit hold_calc = 0, hold_sort = 0;

    int         mcyc = 0;
    logic [9:0] addr_q[$];
    int         wr_idx_q[$];
    int         wr_pad_q[$];
    int         wr_cyc_q[$];
    int         n_calc, n_sort, n_err, n_req, n_res, sort_cyc;

    knn_scheduler #(.L(3), .TYPE_W(4), .ADDR_W(10), .TIMEOUT(15)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_query_valid(query_valid), .o_query_ready(query_ready),
        .i_query_count(query_count), .i_query_base(query_base), .i_query_abort(query_abort),
        .o_mem_req(mem_req), .o_mem_addr(mem_addr), .i_mem_ack(mem_ack),
        .o_calc_start(calc_start), .i_calc_done(calc_done),
        .o_slot_write(slot_write), .o_slot_pad(slot_pad), .o_slot_index(slot_index),
        .o_sort_start(sort_start), .i_sort_valid(sort_valid),
        .i_infer_done(infer_done), .i_infer_type(infer_type),
        .o_result_valid(result_valid), .o_result_type(result_type), .i_result_ready(result_ready),
        .o_busy(busy), .o_err(err), .o_err_code(err_code)
    );

    always #5 clk = ~clk;

    // Responders are driven, then the handshake that the next rising edge will see is logged.
    initial begin
        forever begin
            @(negedge clk);
            mcyc++;
            case (rmode)
                1: begin
                    mem_ack = 1; calc_done = !hold_calc; sort_valid = !hold_sort; infer_done = 1;
                end
                2: begin
                    mem_ack    = ($urandom_range(0, 3) != 0);
                    calc_done  = ($urandom_range(0, 3) != 0) && !hold_calc;
                    sort_valid = ($urandom_range(0, 3) != 0) && !hold_sort;
                    infer_done = ($urandom_range(0, 3) != 0);
                end
                default: begin
                    mem_ack = 0; calc_done = 0; sort_valid = 0; infer_done = 0;
                end
            endcase
            if (rst_n) begin
                if (mem_req) n_req++;
                if (mem_req && mem_ack) addr_q.push_back(mem_addr);
                if (slot_write) begin
                    wr_idx_q.push_back(int'(slot_index));
                    wr_pad_q.push_back(int'(slot_pad));
                    wr_cyc_q.push_back(mcyc);
                end
                if (calc_start) n_calc++;
                if (sort_start) begin n_sort++; sort_cyc = mcyc; end
                if (err) n_err++;
                if (result_valid) n_res++;
            end
        end
    end

    task automatic clear_mon();
        addr_q.delete(); wr_idx_q.delete(); wr_pad_q.delete(); wr_cyc_q.delete();
        n_calc = 0; n_sort = 0; n_err = 0; n_req = 0; n_res = 0; sort_cyc = -1;
    endtask

    // Leaves the caller at the first falling edge after the accepting rising edge.
    task automatic start_query(input int cnt, input int base);
        @(negedge clk);
        query_valid = 1; query_count = 4'(cnt); query_base = 10'(base);
        @(negedge clk);
        query_valid = 0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!result_valid && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_result();
        result_ready = 1;
        @(negedge clk);
        result_ready = 0;
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL result_release valid=%0b busy=%0b required 0 0", result_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (query_ready !== 1'b1) begin failures++; $display("FAIL reset_query_ready got=%0b required=1", query_ready); end
        checks++;
        if ({busy, mem_req, calc_start, slot_write, slot_pad, sort_start, result_valid, err} !== 8'h00) begin
            failures++; $display("FAIL reset_strobes got=%b required=00000000",
                {busy, mem_req, calc_start, slot_write, slot_pad, sort_start, result_valid, err});
        end
        checks++;
        if ({mem_addr, slot_index, result_type, err_code} !== 19'h0) begin
            failures++; $display("FAIL reset_buses got=%h required=0", {mem_addr, slot_index, result_type, err_code});
        end
        rst_n = 1;
    endtask

    task automatic test_full_batch();
        int lat;
        logic [3:0] itype;
        clear_mon();
        rmode = 1;
        itype = 4'($urandom_range(0, 15));
        infer_type = itype;
        start_query(8, 'h10);
        checks++;
        if (busy !== 1'b1 || query_ready !== 1'b0) begin
            failures++; $display("FAIL full_busy busy=%0b ready=%0b required 1 0", busy, query_ready);
        end
        wait_result(lat);
        checks++;
        if (lat != 35) begin failures++; $display("FAIL full_latency got=%0d required=35", lat); end
        checks++;
        if (result_type !== itype) begin failures++; $display("FAIL full_type got=%0d required=%0d", result_type, itype); end
        checks++;
        if (addr_q.size() != 8) begin failures++; $display("FAIL full_fetch_count got=%0d required=8", addr_q.size()); end
        for (int i = 0; i < addr_q.size() && i < 8; i++) begin
            checks++;
            if (addr_q[i] !== 10'('h10 + i)) begin
                failures++; $display("FAIL full_addr%0d got=%h required=%h", i, addr_q[i], 'h10 + i);
            end
        end
        checks++;
        if (wr_idx_q.size() != 8) begin failures++; $display("FAIL full_write_count got=%0d required=8", wr_idx_q.size()); end
        for (int i = 0; i < wr_idx_q.size() && i < 8; i++) begin
            checks++;
            if (wr_idx_q[i] != i || wr_pad_q[i] != 0) begin
                failures++; $display("FAIL full_write%0d idx=%0d pad=%0d required idx=%0d pad=0", i, wr_idx_q[i], wr_pad_q[i], i);
            end
        end
        checks++;
        if (n_sort != 1 || n_calc != 8 || n_err != 0) begin
            failures++; $display("FAIL full_counts sort=%0d calc=%0d err=%0d required 1 8 0", n_sort, n_calc, n_err);
        end
        finish_result();
    endtask

    task automatic test_pad();
        int lat;
        clear_mon();
        rmode = 1;
        infer_type = 4'($urandom_range(0, 15));
        start_query(5, $urandom_range(0, 1023));
        wait_result(lat);
        checks++;
        if (lat != 4 * 5 + 3 + 3) begin failures++; $display("FAIL pad_latency got=%0d required=%0d", lat, 26); end
        checks++;
        if (wr_idx_q.size() != 8) begin failures++; $display("FAIL pad_write_count got=%0d required=8", wr_idx_q.size()); end
        for (int i = 0; i < wr_idx_q.size() && i < 8; i++) begin
            checks++;
            if (wr_idx_q[i] != i || wr_pad_q[i] != (i >= 5 ? 1 : 0)) begin
                failures++; $display("FAIL pad_write%0d idx=%0d pad=%0d required idx=%0d pad=%0d",
                    i, wr_idx_q[i], wr_pad_q[i], i, (i >= 5 ? 1 : 0));
            end
        end
        if (wr_cyc_q.size() == 8) begin
            checks++;
            if (wr_cyc_q[6] != wr_cyc_q[5] + 1 || wr_cyc_q[7] != wr_cyc_q[6] + 1 || sort_cyc != wr_cyc_q[7] + 1) begin
                failures++; $display("FAIL pad_timing cyc5=%0d cyc6=%0d cyc7=%0d sort=%0d required consecutive",
                    wr_cyc_q[5], wr_cyc_q[6], wr_cyc_q[7], sort_cyc);
            end
        end
        finish_result();
    endtask

    task automatic test_bad_count();
        int bad[3] = '{0, 9, 15};
        rmode = 1;
        foreach (bad[j]) begin
            clear_mon();
            start_query(bad[j], 'h40);
            checks++;
            if (err !== 1'b1 || err_code !== 2'd1) begin
                failures++; $display("FAIL bad_count%0d err=%0b code=%0d required 1 1", bad[j], err, err_code);
            end
            checks++;
            if (query_ready !== 1'b1 || busy !== 1'b0) begin
                failures++; $display("FAIL bad_idle%0d ready=%0b busy=%0b required 1 0", bad[j], query_ready, busy);
            end
            repeat (3) @(negedge clk);
            checks++;
            if (n_req != 0 || n_err != 1) begin
                failures++; $display("FAIL bad_side%0d mem_req_cycles=%0d errs=%0d required 0 1", bad[j], n_req, n_err);
            end
        end
    endtask

    task automatic test_timeout();
        int lat;
        clear_mon();
        rmode = 1; hold_calc = 1;
        start_query(3, 'h20);
        lat = 0;
        while (!err && lat < 100) begin @(negedge clk); lat++; end
        checks++;
        if (err !== 1'b1 || err_code !== 2'd2 || lat != 17) begin
            failures++; $display("FAIL timeout err=%0b code=%0d at=%0d required 1 2 17", err, err_code, lat);
        end
        checks++;
        if (busy !== 1'b0 || query_ready !== 1'b1) begin
            failures++; $display("FAIL timeout_idle busy=%0b ready=%0b required 0 1", busy, query_ready);
        end
        hold_calc = 0;
    endtask

    task automatic test_abort();
        int n;
        clear_mon();
        rmode = 1; hold_sort = 1;
        start_query(8, 0);
        n = 0;
        while (!sort_start && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (sort_start !== 1'b1) begin failures++; $display("FAIL abort_reach_sort got=%0b required=1", sort_start); end
        @(negedge clk);
        query_abort = 1;
        @(negedge clk);
        query_abort = 0;
        checks++;
        if (err !== 1'b1 || err_code !== 2'd3 || busy !== 1'b0) begin
            failures++; $display("FAIL abort err=%0b code=%0d busy=%0b required 1 3 0", err, err_code, busy);
        end
        hold_sort = 0;
        repeat (6) @(negedge clk);
        checks++;
        if (n_res != 0 || n_err != 1) begin
            failures++; $display("FAIL abort_after results=%0d errs=%0d required 0 1", n_res, n_err);
        end
        clear_mon();
        query_abort = 1;
        repeat (2) @(negedge clk);
        query_abort = 0;
        checks++;
        if (n_err != 0 || busy !== 1'b0) begin
            failures++; $display("FAIL abort_idle errs=%0d busy=%0b required 0 0", n_err, busy);
        end
    endtask

    task automatic test_result_hold();
        int lat;
        logic [3:0] itype;
        rmode = 1;
        itype = 4'($urandom_range(0, 15));
        infer_type = itype;
        start_query($urandom_range(1, 8), $urandom_range(0, 1023));
        wait_result(lat);
        infer_type = ~itype;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (result_valid !== 1'b1 || result_type !== itype) begin
                failures++; $display("FAIL hold%0d valid=%0b type=%0d required 1 %0d", c, result_valid, result_type, itype);
            end
            @(negedge clk);
        end
        finish_result();
    endtask

    task automatic test_random();
        int lat, cnt, base, minlat;
        logic [3:0] itype;
        rmode = 2;
        for (int it = 0; it < 24; it++) begin
            clear_mon();
            cnt  = $urandom_range(1, 8);
            base = (it % 4 == 0) ? 1020 + $urandom_range(0, 3) : $urandom_range(0, 1023);
            itype = 4'($urandom_range(0, 15));
            infer_type = itype;
            minlat = 4 * cnt + (8 - cnt) + 3;
            start_query(cnt, base);
            wait_result(lat);
            checks++;
            if (result_valid !== 1'b1 || result_type !== itype || lat < minlat) begin
                failures++; $display("FAIL rand%0d_result valid=%0b type=%0d lat=%0d required 1 %0d >=%0d",
                    it, result_valid, result_type, lat, itype, minlat);
            end
            checks++;
            if (addr_q.size() != cnt || wr_idx_q.size() != 8 || n_sort != 1 || n_err != 0) begin
                failures++; $display("FAIL rand%0d_counts fetch=%0d writes=%0d sort=%0d err=%0d required %0d 8 1 0",
                    it, addr_q.size(), wr_idx_q.size(), n_sort, n_err, cnt);
            end
            for (int i = 0; i < addr_q.size() && i < cnt; i++) begin
                checks++;
                if (addr_q[i] !== 10'((base + i) % 1024)) begin
                    failures++; $display("FAIL rand%0d_addr%0d got=%h required=%h", it, i, addr_q[i], (base + i) % 1024);
                end
            end
            for (int i = 0; i < wr_idx_q.size() && i < 8; i++) begin
                checks++;
                if (wr_idx_q[i] != i || wr_pad_q[i] != (i >= cnt ? 1 : 0)) begin
                    failures++; $display("FAIL rand%0d_write%0d idx=%0d pad=%0d required %0d %0d",
                        it, i, wr_idx_q[i], wr_pad_q[i], i, (i >= cnt ? 1 : 0));
                end
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            finish_result();
        end
    endtask

    task automatic test_reset_mid_fetch();
        clear_mon();
        rmode = 0;
        start_query(4, 'h55);
        checks++;
        if (mem_req !== 1'b1) begin failures++; $display("FAIL rst_pre_fetch mem_req=%0b required=1", mem_req); end
        #2 rst_n = 0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || query_ready !== 1'b1) begin
            failures++; $display("FAIL rst_async mem_req=%0b busy=%0b ready=%0b required 0 0 1", mem_req, busy, query_ready);
        end
        @(negedge clk);
        rst_n = 1;
        rmode = 1;
        clear_mon();
        repeat (20) @(negedge clk);
        checks++;
        if (n_req != 0 || n_calc != 0 || wr_idx_q.size() != 0 || n_res != 0 || n_err != 0) begin
            failures++; $display("FAIL rst_quiet req=%0d calc=%0d writes=%0d res=%0d err=%0d required all 0",
                n_req, n_calc, wr_idx_q.size(), n_res, n_err);
        end
    endtask

    initial begin
        query_valid = 0; query_abort = 0; query_count = 0; query_base = 0;
        mem_ack = 0; calc_done = 0; sort_valid = 0; infer_done = 0; infer_type = 0; result_ready = 0;
        clear_mon();
        test_reset();
        test_full_batch();
        test_pad();
        test_bad_count();
        test_timeout();
        test_abort();
        test_result_hold();
        test_random();
        test_reset_mid_fetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
